ex_mult_sequencer: RTL and testbench



---
 rtl/ex_mult_sequencer.sv | 104 ++++++++++
 tb/tb_ex_mult_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mult_sequencer.sv
// Multi-cycle shift-add multiplier for the EX stage: one multiplier bit per cycle,
// stalls the front of the pipeline while running and pulses done with the product.
module ex_mult_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic               stall,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [1:0]         dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is a level qualifier from EX; stall is asserted combinationally
    // in the same cycle start is accepted and stays high until the last RUN cycle.
    // done is a single-cycle registered pulse, result holds until the next completion.

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  mcand;
    logic [2*WIDTH:0]  prod;
    logic [2*WIDTH:0]  prod_step;
    logic [WIDTH:0]    sum;
    logic [CW-1:0]     count;
    logic              last;
    logic              accept;

    assign dbg_state = state;
    assign accept    = start && !flush;
    assign last      = (count == CW'(WIDTH - 1));

    // One shift-add step: conditional add into the upper half, then shift right by one.
    always_comb begin
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_step = {1'b0, sum, prod[WIDTH-1:1]};
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    stall     = 1'b1;
                end
            end
            RUN: begin
                stall = !flush;
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            prod   <= '0;
            count  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= dataa;
                        prod  <= {1'b0, {WIDTH{1'b0}}, datab};
                        count <= '0;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        prod  <= prod_step;
                        count <= count + CW'(1);
                        if (last) result <= prod_step[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mult_sequencer.sv
// Directed bench for ex_mult_sequencer: latency, products, flush, back-to-back and
// mid-operation reset, each scenario in its own task.
module tb_ex_mult_sequencer;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           flush;
    logic [W-1:0]   dataa;
    logic [W-1:0]   datab;
    logic           stall;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic [1:0]     dbg_state;

    int checks;
    int errors;

    ex_mult_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .dataa     (dataa),
        .datab     (datab),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap busy=%0b done=%0b required not both high", busy, done);
            end
        end
    end

    // Starts an operation at the next cycle and returns at the negedge of the done cycle.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic hold,
                            output int stall_n, output int done_at);
        @(posedge clk); #1;
        dataa = a; datab = b; start = 1'b1;
        stall_n = 0; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (done) begin
                done_at = c;
                break;
            end
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
        end
    endtask

    task automatic check_mult(input string name, input int stall_n, input int done_at,
                              input logic [2*W-1:0] exp);
        checks++;
        if (done_at !== 17) begin
            errors++;
            $display("FAIL %s_done_cycle got %0d expected 17", name, done_at);
        end
        checks++;
        if (stall_n !== 17) begin
            errors++;
            $display("FAIL %s_stall_cycles got %0d expected 17", name, stall_n);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s_result got %h expected %h", name, result, exp);
        end
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL %s_done_state stall=%0b busy=%0b state=%0d expected 0 0 2", name, stall, busy, dbg_state);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_after state=%0d done=%0b stall=%0b expected 0 0 0", name, dbg_state, done, stall);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; dataa = '0; datab = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset busy=%0b done=%0b stall=%0b result=%h state=%0d expected all 0",
                     busy, done, stall, result, dbg_state);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int sn, da;
        run_mult(16'h0003, 16'h0005, 1'b1, sn, da);
        check_mult("basic", sn, da, 32'h0000000F);
    endtask

    task automatic test_carry();
        int sn, da;
        run_mult(16'hFFFF, 16'hFFFF, 1'b0, sn, da);
        check_mult("carry", sn, da, 32'hFFFE0001);
    endtask

    task automatic test_signed();
        int sn, da;
        run_mult(16'hFFFD, 16'h0007, 1'b0, sn, da);
        check_mult("signed", sn, da, 32'h0006FFEB);
        checks++;
        if (result[15:0] !== 16'hFFEB) begin
            errors++;
            $display("FAIL signed_low got %h expected ffeb", result[15:0]);
        end
    endtask

    task automatic test_flush();
        int dones;
        @(posedge clk); #1;
        dataa = 16'h0003; datab = 16'h0005; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_run_cycle stall=%0b busy=%0b expected 0 1", stall, busy);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle state=%0d busy=%0b expected 0 0", dbg_state, busy);
        end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || result !== 32'h0006FFEB) begin
            errors++;
            $display("FAIL flush_no_done dones=%0d result=%h expected 0 0006ffeb", dones, result);
        end
        // start and flush together must not launch anything
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_stall got %0b expected 0", stall);
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy || dbg_state !== 2'd0) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL flush_start_busy non-idle cycles got %0d expected 0", dones);
        end
    endtask

    task automatic test_zero();
        int sn, da;
        run_mult(16'h0000, 16'h1234, 1'b0, sn, da);
        check_mult("zero", sn, da, 32'h00000000);
    endtask

    task automatic test_back_to_back();
        int sn, da;
        run_mult(16'h0003, 16'h0005, 1'b1, sn, da);
        check_mult("b2b_first", sn, da, 32'h0000000F);
        run_mult(16'h0002, 16'h0004, 1'b0, sn, da);
        check_mult("b2b_second", sn, da, 32'h00000008);
    endtask

    task automatic test_reset_mid();
        int sn, da;
        @(posedge clk); #1;
        dataa = 16'h1111; datab = 16'h0002; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%0b done=%0b stall=%0b result=%h state=%0d expected all 0",
                     busy, done, stall, result, dbg_state);
        end
        run_mult(16'h0006, 16'h0007, 1'b0, sn, da);
        check_mult("after_reset", sn, da, 32'h0000002A);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        dataa  = '0;
        datab  = '0;
        test_reset();
        test_basic();
        test_carry();
        test_signed();
        test_flush();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
